mips_cpu_lsu: RTL
=================

# mips_cpu_lsu

Load/store unit between the `mips_cpu_harvard` execute stage and `mips_cpu_data_memory`.
- Turns every CPU data access (LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW) into word-aligned memory transactions.
- Performs big-endian byte-lane extraction, sign/zero extension and LWL/LWR merging.
- Implements sub-word stores as read-modify-write sequences.
- Holds the CPU in a stall while a transaction is in flight.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `cpu_read`  in  1: load request; held stable until `cpu_done`.
- `cpu_write`  in  1: store request; held stable until `cpu_done`.
- `cpu_op`  in  4: `lsu_op_t` opcode.
- `cpu_addr`  in  ADDR_W: byte address.
- `cpu_wdata`  in  32: store data; the low byte or half is used for SB/SH.
- `cpu_rt_old`  in  32: current rt value, used for the LWL/LWR merge.
- `cpu_rdata`  out  32: registered load result, valid while `cpu_done` is high.
- `cpu_stall`  out  1: high while a request is present and not yet complete.
- `cpu_done`  out  1: one-cycle completion pulse.
- `cpu_addr_err`  out  1: valid with `cpu_done`; flags a misaligned or illegal request.
- `mem_address`  out  ADDR_W: word address, low two bits always 0.
- `mem_read`  out  1: memory read strobe.
- `mem_write`  out  1: memory write strobe.
- `mem_writedata`  out  32: memory write data.
- `mem_readdata`  in  32: memory read data, valid the cycle after `mem_read` is high.

## Operation
- **Byte order:** big-endian. Byte offset o = `cpu_addr[1:0]`; offset 0 is bits 31:24.
- **FSM states:** IDLE, RD, CAP, WR, DONE.
- **From IDLE, sampled on the clock edge:**
  - Misaligned LW/SW (o≠0), misaligned LH/LHU/SH (o[0]=1), or `cpu_read` && `cpu_write` -> DONE with err=1. No memory strobe is issued.
  - Any load, SB or SH -> RD.
  - SW -> WR.
- **RD:** `mem_read`=1, `mem_address`={addr[31:2],2'b00}. Next state is CAP.
- **CAP:** capture `mem_readdata`.
  - Load: compute the result into `cpu_rdata`, then -> DONE.
  - SB/SH: compute the merged word into the write register, then -> WR.
- **WR:** `mem_write`=1 with `mem_writedata` set to the merged word, or to `cpu_wdata` for SW. Next state is DONE.
- **DONE:** `cpu_done`=1, `cpu_stall`=0. Next state is IDLE. A new request is accepted in IDLE no earlier than the cycle after DONE.
- **`cpu_stall`:** (`cpu_read`|`cpu_write`) && state≠DONE.
- **Load extraction:**
  - LB/LBU: byte o, sign- or zero-extended to 32 bits.
  - LH/LHU: half at o, sign- or zero-extended.
  - LW: the whole word.
- **LWL:** result = (mem << 8o) | (`cpu_rt_old` & ~(32'hFFFFFFFF << 8o)).
- **LWR:** result = (mem >> 8(3−o)) | (`cpu_rt_old` & ~(32'hFFFFFFFF >> 8(3−o))).
- **SB/SH merge:** replace only the addressed lanes of the read word; all other bytes are preserved.
- **Strobes:** `mem_read` and `mem_write` are never high in the same cycle.

## Timing
- **Reset:** asynchronous. State goes to IDLE, all outputs go to 0 immediately, and any in-flight `mem_write` is dropped that same instant. Assertion of `reset` is asynchronous; deassertion is synchronised externally.
- **Latency, request seen in IDLE at edge 0:**
  - Load: RD in cycle 1, CAP in cycle 2, `cpu_done` in cycle 3.
  - SW: WR in cycle 1, `cpu_done` in cycle 2.
  - SB/SH: RD, CAP, WR, then `cpu_done` in cycle 4.
  - Error: `cpu_done` in cycle 1.
- **Registers:** `cpu_rdata` holds its value until the next load completes. `cpu_addr_err` clears on the next DONE without error.
- **Request dropped mid-transaction:** the FSM still finishes the transaction and pulses `cpu_done`. The CPU is required not to do this.

## Structure
- **Package `mips_lsu_pkg`:**
  - `lsu_op_t` enum: LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW.
  - `lsu_state_t` enum.
  - Helper constant `WORD_MASK`.
- **Sub-module `mips_lsu_align`:** purely combinational; inputs op, offset, mem word, rt_old and wdata; outputs load result and merged store word.
- **Top level:** FSM and registers only.

## Test plan
- Memory[0]=0x11223344, LB at addr 1 -> `cpu_rdata`=0x00000022 at cycle 3. LB at addr 0 with mem 0x80xxxxxx -> 0xFFFFFF80.
- LWL addr 2, mem 0x11223344, rt_old 0xAABBCCDD -> 0x3344CCDD. LWR addr 1, same inputs -> 0xAABB1122.
- SB wdata 0x000000EE to addr 5, memory[4]=0x55667788 -> memory[4]=0x55EE7788. `mem_write` is high exactly once, in cycle 3.
- LW addr 2 -> `cpu_addr_err`=1 and `cpu_done` in cycle 1. Neither `mem_read` nor `mem_write` ever asserts.
- Back-to-back SW to addr 8 then LW from addr 8 -> the stored word is returned and `cpu_stall` drops only in DONE cycles.
- `reset` asserted mid-cycle during WR of an SH -> `mem_write` falls immediately, memory is unchanged, and the FSM is in IDLE on release.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// Shared types and helpers for the MIPS load/store unit.
// Holds the access opcode enum, the FSM state enum, the all-ones word mask
// and small decode helpers used by both the LSU and its align datapath.
package mips_lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam logic [DATA_W-1:0] WORD_MASK = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SB  = 4'd7,
        SH  = 4'd8,
        SW  = 4'd9
    } lsu_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } lsu_state_t;

    function automatic logic is_load(input lsu_op_t op);
        return op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
    endfunction

    function automatic logic is_store(input lsu_op_t op);
        return op inside {SB, SH, SW};
    endfunction

    // Words need offset 0, halves need an even offset; LWL/LWR are unaligned by design.
    function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] offset);
        case (op)
            LW, SW:      return offset != 2'd0;
            LH, LHU, SH: return offset[0];
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_if.sv
// CPU-side request/response and memory-side bus of the load/store unit.
// slave  : view of the LSU (accepts CPU requests, masters the memory bus).
// master : view of the environment (CPU issuing requests, memory answering).
interface mips_cpu_lsu_if
    import mips_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) ();

    logic              cpu_read;
    logic              cpu_write;
    lsu_op_t           cpu_op;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rt_old;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              cpu_done;
    logic              cpu_addr_err;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;

    modport slave (
        input  cpu_read, cpu_write, cpu_op, cpu_addr, cpu_wdata, cpu_rt_old,
        input  mem_readdata,
        output cpu_rdata, cpu_stall, cpu_done, cpu_addr_err,
        output mem_address, mem_read, mem_write, mem_writedata
    );

    modport master (
        output cpu_read, cpu_write, cpu_op, cpu_addr, cpu_wdata, cpu_rt_old,
        output mem_readdata,
        input  cpu_rdata, cpu_stall, cpu_done, cpu_addr_err,
        input  mem_address, mem_read, mem_write, mem_writedata
    );

endinterface

// File: rtl/mips_lsu_align.sv
// Combinational big-endian lane logic for the load/store unit.
// Inputs : op, byte offset, memory word, old rt value, store data.
// Outputs: load_result (extracted/extended/merged load value),
//          store_word  (read word with the addressed lanes replaced, or wdata for SW).
module mips_lsu_align
    import mips_lsu_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_word,
    input  logic [31:0] rt_old,
    input  logic [31:0] wdata,
    output logic [31:0] load_result,
    output logic [31:0] store_word
);

    // Offset 0 is the most significant byte, so lanes sit at shift 8*(3-o).
    logic [4:0]  lwl_sh;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;

    always_comb begin
        lwl_sh    = {offset, 3'b000};
        byte_sh   = {~offset, 3'b000};
        half_sh   = {~offset[1], 4'b0000};
        byte_val  = 8'(mem_word >> byte_sh);
        half_val  = 16'(mem_word >> half_sh);
        byte_mask = 32'h0000_00FF << byte_sh;
        half_mask = 32'h0000_FFFF << half_sh;
    end

    // Load path
    always_comb begin
        load_result = mem_word;
        case (op)
            LB:      load_result = {{24{byte_val[7]}}, byte_val};
            LBU:     load_result = {24'h0, byte_val};
            LH:      load_result = {{16{half_val[15]}}, half_val};
            LHU:     load_result = {16'h0, half_val};
            LWL:     load_result = (mem_word << lwl_sh) | (rt_old & ~(WORD_MASK << lwl_sh));
            LWR:     load_result = (mem_word >> byte_sh) | (rt_old & ~(WORD_MASK >> byte_sh));
            default: load_result = mem_word;
        endcase
    end

    // Store path: read-modify-write merge for sub-word stores
    always_comb begin
        store_word = wdata;
        case (op)
            SB:      store_word = (mem_word & ~byte_mask) | ((32'(wdata[7:0]) << byte_sh) & byte_mask);
            SH:      store_word = (mem_word & ~half_mask) | ((32'(wdata[15:0]) << half_sh) & half_mask);
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit between the CPU execute stage and the data memory.
// Ports: clk, reset (async, active-high), bus (mips_cpu_lsu_if.slave) carrying
//        the CPU request/response and the word-aligned memory strobes.
// Loads: IDLE->RD->CAP->DONE. SW: IDLE->WR->DONE. SB/SH: IDLE->RD->CAP->WR->DONE.
// Illegal or misaligned requests go straight to DONE with cpu_addr_err set.
module mips_cpu_lsu
    import mips_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    mips_cpu_lsu_if.slave  bus
);

    lsu_state_t state;
    lsu_state_t state_nxt;
    logic       err_nxt;
    logic       req;
    logic       illegal;

    lsu_op_t     op_q;
    logic [1:0]  off_q;
    logic [31:0] load_result;
    logic [31:0] store_word;

    assign req = bus.cpu_read | bus.cpu_write;

    // Reject both strobes together, direction/opcode mismatches and misalignment.
    assign illegal = (bus.cpu_read & bus.cpu_write)
                   | (bus.cpu_read  & ~is_load(bus.cpu_op))
                   | (bus.cpu_write & ~is_store(bus.cpu_op))
                   | is_misaligned(bus.cpu_op, bus.cpu_addr[1:0]);

    // Stall is a live function of the request; forced low while in reset.
    assign bus.cpu_stall = req && (state != DONE) && !reset;

    mips_lsu_align u_align (
        .op          (op_q),
        .offset      (off_q),
        .mem_word    (bus.mem_readdata),
        .rt_old      (bus.cpu_rt_old),
        .wdata       (bus.cpu_wdata),
        .load_result (load_result),
        .store_word  (store_word)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (illegal) begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end else if (bus.cpu_op == SW) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD:      state_nxt = CAP;
            CAP:     state_nxt = is_load(op_q) ? DONE : WR;
            WR:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs and transaction context
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_read      <= 1'b0;
            bus.mem_write     <= 1'b0;
            bus.mem_address   <= '0;
            bus.mem_writedata <= '0;
            bus.cpu_done      <= 1'b0;
            bus.cpu_rdata     <= '0;
            bus.cpu_addr_err  <= 1'b0;
            op_q              <= LB;
            off_q             <= 2'd0;
        end else begin
            bus.mem_read  <= (state_nxt == RD);
            bus.mem_write <= (state_nxt == WR);
            bus.cpu_done  <= (state_nxt == DONE);

            // Latch the request so an in-flight transaction completes consistently.
            if (state == IDLE && req) begin
                op_q            <= bus.cpu_op;
                off_q           <= bus.cpu_addr[1:0];
                bus.mem_address <= {bus.cpu_addr[ADDR_W-1:2], 2'b00};
            end

            if (state == IDLE && state_nxt == WR) begin
                bus.mem_writedata <= bus.cpu_wdata;
            end

            if (state == CAP) begin
                if (is_load(op_q)) begin
                    bus.cpu_rdata <= load_result;
                end else begin
                    bus.mem_writedata <= store_word;
                end
            end

            if (state_nxt == DONE) begin
                bus.cpu_addr_err <= err_nxt;
            end
        end
    end

endmodule
